// File: rtl/div_unit_pkg.sv
// Shared definitions for the Hi/Lo divide path: FSM encodings, default width
// and the Hi_src/Lo_src select values used by the control unit.
package div_unit_pkg;

    localparam int DIV_WIDTH = 32;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_CALC = 2'd1,
        DIV_FIX  = 2'd2
    } div_state_t;

    // Hi/Lo write-source selects driven by the control unit
    localparam logic [1:0] HILO_SRC_ALU  = 2'd0;
    localparam logic [1:0] HILO_SRC_MULT = 2'd1;
    localparam logic [1:0] HILO_SRC_DIV  = 2'd2;
    localparam logic [1:0] HILO_SRC_RS   = 2'd3;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division step on magnitudes: shift {rem,quo} left,
// subtract the divisor when it fits and record the quotient bit.
module div_step
    import div_unit_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH:0]   i_rem,
    input  logic [WIDTH-1:0] i_quo,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH:0]   o_rem,
    output logic [WIDTH-1:0] o_quo
);

    logic [WIDTH+1:0] w_shifted;
    logic [WIDTH+1:0] w_diff;
    logic             w_fits;

    assign w_shifted = {i_rem, i_quo[WIDTH-1]};
    assign w_diff    = w_shifted - {2'b00, i_divisor};
    assign w_fits    = (w_shifted >= {2'b00, i_divisor});

    always_comb begin
        o_rem = w_fits ? (WIDTH+1)'(w_diff) : (WIDTH+1)'(w_shifted);
        o_quo = {i_quo[WIDTH-2:0], w_fits};
    end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle signed divider: WIDTH restoring steps on operand magnitudes,
// then one cycle applying the quotient/remainder signs to Lo/Hi.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi
);

    div_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH:0]   r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_dvs;
    logic             r_q_neg;
    logic             r_r_neg;
    logic             r_busy;
    logic             r_done;
    logic             r_div_zero;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_hi;

    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic             w_b_zero;
    logic [WIDTH:0]   w_rem_nx;
    logic [WIDTH-1:0] w_quo_nx;

    // Unsigned magnitudes: the most negative value maps onto itself
    assign w_a_mag  = dividend[WIDTH-1] ? -dividend : dividend;
    assign w_b_mag  = divisor[WIDTH-1]  ? -divisor  : divisor;
    assign w_b_zero = (divisor == '0);

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_rem     (r_rem),
        .i_quo     (r_quo),
        .i_divisor (r_dvs),
        .o_rem     (w_rem_nx),
        .o_quo     (w_quo_nx)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= DIV_IDLE;
            r_cnt      <= '0;
            r_rem      <= '0;
            r_quo      <= '0;
            r_dvs      <= '0;
            r_q_neg    <= 1'b0;
            r_r_neg    <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
            r_lo       <= '0;
            r_hi       <= '0;
        end else begin
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
            unique case (r_state)
                DIV_IDLE: begin
                    if (start) begin
                        if (w_b_zero) begin
                            r_done     <= 1'b1;
                            r_div_zero <= 1'b1;
                        end else begin
                            r_quo   <= w_a_mag;
                            r_dvs   <= w_b_mag;
                            r_rem   <= '0;
                            r_q_neg <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                            r_r_neg <= dividend[WIDTH-1];
                            r_cnt   <= CNT_W'(WIDTH);
                            r_busy  <= 1'b1;
                            r_state <= DIV_CALC;
                        end
                    end
                end
                DIV_CALC: begin
                    r_rem <= w_rem_nx;
                    r_quo <= w_quo_nx;
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1))
                        r_state <= DIV_FIX;
                end
                DIV_FIX: begin
                    r_lo    <= r_q_neg ? -r_quo : r_quo;
                    r_hi    <= r_r_neg ? -r_rem[WIDTH-1:0] : r_rem[WIDTH-1:0];
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= DIV_IDLE;
                end
                default: r_state <= DIV_IDLE;
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign div_zero = r_div_zero;
    assign lo       = r_lo;
    assign hi       = r_hi;

endmodule

// File: tb/tb_div_unit.sv
// Bench for div_unit: transaction-level signed-division model compared
// against the DUT outputs every cycle, plus directed literal expectations.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [31:0] lo;
    logic [31:0] hi;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    div_unit #(
        .WIDTH (32),
        .CNT_W (6)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .dividend (dividend),
        .divisor  (divisor),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .lo       (lo),
        .hi       (hi)
    );

    // Signed division: quotient truncates toward zero, remainder follows the dividend
    function automatic logic [31:0] ref_lo(input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        q  = sa / sb;
        return q[31:0];
    endfunction

    function automatic logic [31:0] ref_hi(input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r  = sa % sb;
        return r[31:0];
    endfunction

    // Transaction model: a non-zero divide finishes 33 edges after its start edge
    logic        m_busy = 1'b0, m_done = 1'b0, m_dz = 1'b0;
    logic [31:0] m_lo = '0, m_hi = '0, m_plo = '0, m_phi = '0;
    int          m_left = 0;

    always @(posedge clk) begin
        if (reset) begin
            m_busy <= 1'b0; m_done <= 1'b0; m_dz <= 1'b0;
            m_lo <= '0; m_hi <= '0; m_left <= 0;
        end else begin
            m_done <= 1'b0;
            m_dz   <= 1'b0;
            if (m_left == 0) begin
                if (start) begin
                    if (divisor == 32'd0) begin
                        m_done <= 1'b1;
                        m_dz   <= 1'b1;
                    end else begin
                        m_left <= 33;
                        m_busy <= 1'b1;
                        m_plo  <= ref_lo(dividend, divisor);
                        m_phi  <= ref_hi(dividend, divisor);
                    end
                end
            end else begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_busy <= 1'b0;
                    m_done <= 1'b1;
                    m_lo   <= m_plo;
                    m_hi   <= m_phi;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy",     32'(busy),     32'(m_busy));
            check("done",     32'(done),     32'(m_done));
            check("div_zero", 32'(div_zero), 32'(m_dz));
            check("lo",       lo,            m_lo);
            check("hi",       hi,            m_hi);
        end
    end

    // Issues one start at the current negedge, then watches up to 40 negedges.
    task automatic run(input logic [31:0] a, input logic [31:0] b,
                       input int s2_k, input int rst_k, input bit stop,
                       output int lat, output int busyc, output int ndone,
                       output logic dzd);
        start = 1'b1; dividend = a; divisor = b;
        lat = 0; busyc = 0; ndone = 0; dzd = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            start    = (k == s2_k);
            reset    = (k == rst_k);
            dividend = $urandom;
            divisor  = $urandom;
            if (busy) busyc++;
            if (done) begin
                ndone++;
                if (lat == 0) begin
                    lat = k;
                    dzd = div_zero;
                end
                if (stop) break;
            end
        end
        reset = 1'b0;
        start = 1'b0;
    endtask

    task automatic div_expect(input string name, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] elo, input logic [31:0] ehi);
        int lat, busyc, ndone;
        logic dzd;
        run(a, b, 0, 0, 1'b1, lat, busyc, ndone, dzd);
        check({name, " latency"}, 32'(lat), 32'd34);
        check({name, " busy cycles"}, 32'(busyc), 32'd33);
        check({name, " dz"}, 32'(dzd), 32'd0);
        check({name, " lo"}, lo, elo);
        check({name, " hi"}, hi, ehi);
    endtask

    initial begin
        int lat, busyc, ndone;
        logic dzd;
        logic [31:0] a, b;
        reset = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk_en = 1'b1;
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset lo", lo, 32'd0);
        check("reset hi", hi, 32'd0);

        div_expect("100/7", 32'd100, 32'd7, 32'd14, 32'd2);

        run(32'd5, 32'd0, 0, 0, 1'b1, lat, busyc, ndone, dzd);
        check("5/0 latency", 32'(lat), 32'd1);
        check("5/0 dz", 32'(dzd), 32'd1);
        check("5/0 busy cycles", 32'(busyc), 32'd0);
        check("5/0 lo kept", lo, 32'd14);
        check("5/0 hi kept", hi, 32'd2);

        div_expect("-100/7",  -32'sd100, 32'd7,    32'hFFFFFFF2, 32'hFFFFFFFE);
        div_expect("100/-7",  32'd100,   -32'sd7,  32'hFFFFFFF2, 32'd2);
        div_expect("-100/-7", -32'sd100, -32'sd7,  32'd14,       32'hFFFFFFFE);

        run(32'h80000000, 32'hFFFFFFFF, 10, 0, 1'b0, lat, busyc, ndone, dzd);
        check("ovf latency", 32'(lat), 32'd34);
        check("ovf done count", 32'(ndone), 32'd1);
        check("ovf dz", 32'(dzd), 32'd0);
        check("ovf lo", lo, 32'h80000000);
        check("ovf hi", hi, 32'd0);

        run(32'd1000, 32'd3, 0, 12, 1'b0, lat, busyc, ndone, dzd);
        check("abort done count", 32'(ndone), 32'd0);
        check("abort busy", 32'(busy), 32'd0);
        check("abort lo", lo, 32'd0);
        check("abort hi", hi, 32'd0);
        div_expect("1000/3", 32'd1000, 32'd3, 32'd333, 32'd1);

        div_expect("max/1", 32'h7FFFFFFF, 32'd1, 32'h7FFFFFFF, 32'd0);
        div_expect("3/10",  32'd3, 32'd10, 32'd0, 32'd3);
        div_expect("0/-5",  32'd0, -32'sd5, 32'd0, 32'd0);

        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0: a = $urandom;
                1: a = 32'($signed($urandom_range(0, 2000)) - 1000);
                2: a = 32'h80000000;
                default: a = 32'h7FFFFFFF - $urandom_range(0, 3);
            endcase
            case ($urandom_range(0, 4))
                0: b = $urandom;
                1: b = 32'($signed($urandom_range(0, 40)) - 20);
                2: b = 32'd0;
                3: b = 32'hFFFFFFFF;
                default: b = $urandom >> $urandom_range(0, 31);
            endcase
            run(a, b, 0, 0, 1'b1, lat, busyc, ndone, dzd);
            check("random latency", 32'(lat), (b == 32'd0) ? 32'd1 : 32'd34);
        end

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
